pipe_stage_skid: RTL

//  Parametrised elastic pipeline stage register; successor of the fixed-field stage registers between ID/EX/MEM/WB.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_perf_ctr.sv | 20 ++
 rtl/pipe_stage_skid.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: state encoding and occupancy width.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_stage_state_e;

    // The encoding is chosen so the state value is exactly the number of held entries.
    function automatic logic [OCC_W-1:0] state_to_occ(input pipe_stage_state_e st);
        return OCC_W'(st);
    endfunction

endpackage

// File: rtl/pipe_perf_ctr.sv
// Saturating event counter used for the stage's stall/bubble statistics.
module pipe_perf_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Sticks at all-ones so a long stall never wraps into a misleadingly small value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage with registered up_ready and flush.
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int CLEAR_ON_BUBBLE = 1,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_stage_state_e state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              up_fire;
    logic              dn_fire;

    assign dn_valid  = (state_q != ST_EMPTY);
    assign up_ready  = (state_q != ST_FULL);
    assign dn_data   = main_q;
    assign occupancy = state_to_occ(state_q);
    assign up_fire   = up_valid && up_ready;
    assign dn_fire   = dn_valid && dn_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // main always feeds dn_data directly; skid only catches the beat that arrives while main is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (up_fire) begin
                    state_d = ST_HALF;
                    main_d  = up_data;
                end
            end
            ST_HALF: begin
                if (up_fire && dn_fire) begin
                    main_d = up_data;
                end else if (up_fire) begin
                    state_d = ST_FULL;
                    skid_d  = up_data;
                end else if (dn_fire) begin
                    state_d = ST_EMPTY;
                    if (CLEAR_ON_BUBBLE != 0) main_d = '0;
                end
            end
            ST_FULL: begin
                if (dn_fire) begin
                    state_d = ST_HALF;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        // Squash wins over everything; a simultaneous downstream accept is simply treated as consumed.
        if (flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_BUBBLE != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (dn_valid && !dn_ready),
        .count (stall_cnt)
    );

    pipe_perf_ctr #(.CNT_W(CNT_W)) u_bubble_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (!dn_valid),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
